mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one memory port between COUNT requesters. A request seen in IDLE is
// granted and its command (rw/address/wdata) is captured, then presented to
// memory with o_request held high (BUSY) until memory answers with i_ready.
// The granted requester gets a one-cycle o_ready pulse, and reads also update
// that requester's o_rdata slice. A single RELEASE cycle with o_request low
// always follows, so memory can drop i_ready before the next grant.
//
// Configuration:
//   MEM_ARBITER_ROUND_ROBIN_EN defined   -> round-robin arbitration with a
//                                           rotating pointer
//   MEM_ARBITER_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins
//
// Parameters:
//   WIDTH  data width of every requester and memory data port
//   COUNT  number of requesters (2..8)
//
// Ports:
//   i_clock, i_reset           clock (rising edge), async active-high reset
//   i_request[COUNT]           per-requester request
//   i_rw[COUNT]                per-requester direction, 0 read / 1 write
//   i_address[COUNT*32]        per-requester byte address, slice n = [32n+:32]
//   i_wdata[COUNT*WIDTH]       per-requester write data
//   o_rdata[COUNT*WIDTH]       per-requester registered read data
//   o_ready[COUNT]             per-requester one-cycle completion pulse
//   o_request/o_rw/o_address/o_wdata   memory-side command
//   i_rdata/i_ready            memory-side response
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [COUNT-1:0]       i_request,
  input  logic [COUNT-1:0]       i_rw,
  input  logic [COUNT*32-1:0]    i_address,
  input  logic [COUNT*WIDTH-1:0] i_wdata,
  output logic [COUNT*WIDTH-1:0] o_rdata,
  output logic [COUNT-1:0]       o_ready,
  output logic                   o_request,
  output logic                   o_rw,
  output logic [31:0]            o_address,
  output logic [WIDTH-1:0]       o_wdata,
  input  logic [WIDTH-1:0]       i_rdata,
  input  logic                   i_ready
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t          state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick;
  logic            any_request;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0]   rr_ptr;

  // Pick the set request closest to the pointer going upward with wrap.
  // Distances are compared per index so every select uses a constant index.
  always_comb begin
    int best;
    int dist;
    pick        = '0;
    any_request = 1'b0;
    best        = COUNT;
    dist        = 0;
    for (int j = 0; j < COUNT; j++) begin
      if (j >= int'(rr_ptr)) dist = j - int'(rr_ptr);
      else                   dist = j + COUNT - int'(rr_ptr);
      if (i_request[j] && dist < best) begin
        best        = dist;
        pick        = IW'(j);
        any_request = 1'b1;
      end
    end
  end

  // Pointer moves just past whoever was granted so that requester goes last.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rr_ptr <= '0;
    end else if (state == IDLE && any_request) begin
      if (pick == IW'(COUNT - 1)) rr_ptr <= '0;
      else                        rr_ptr <= pick + 1'b1;
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index in pick.
  always_comb begin
    pick        = '0;
    any_request = 1'b0;
    for (int j = COUNT - 1; j >= 0; j--) begin
      if (i_request[j]) begin
        pick        = IW'(j);
        any_request = 1'b1;
      end
    end
  end
`endif

  // Transaction sequencer. The command fields are captured once at grant and
  // only change at the next grant, so memory sees a stable command. o_ready
  // defaults low every cycle, which makes the completion a single pulse.
  // Dropping the granted request while BUSY abandons the transaction quietly.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      grant     <= '0;
      o_request <= 1'b0;
      o_rw      <= 1'b0;
      o_address <= '0;
      o_wdata   <= '0;
      o_ready   <= '0;
      o_rdata   <= '0;
    end else begin
      o_ready <= '0;
      case (state)
        IDLE: begin
          if (any_request) begin
            grant     <= pick;
            o_rw      <= i_rw[pick];
            o_address <= i_address[pick*32 +: 32];
            o_wdata   <= i_wdata[pick*WIDTH +: WIDTH];
            o_request <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!i_request[grant]) begin
            o_request <= 1'b0;
            state     <= RELEASE;
          end else if (i_ready) begin
            o_ready[grant] <= 1'b1;
            if (!o_rw) o_rdata[grant*WIDTH +: WIDTH] <= i_rdata;
            o_request <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          o_request <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          o_request <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
